// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller for the five-stage MIPS core. Decides each cycle
// whether the front end must stall (load-use, JR operand wait), whether IF/ID
// must be squashed (taken branch, JR go), and which EX operand bypass to use.
// It also keeps a JR wait watchdog and saturating stall/flush statistics.
//
// Ports
//   CLOCK, RESET_N                 clock, asynchronous active-low reset
//   ENABLED                        ID stage holds a valid instruction
//   rs_addrD, rt_addrD             ID source registers
//   use_rsD, use_rtD, jrD          ID reads rs / reads rt / is jr
//   rs_addrE, rt_addrE             EX source registers (forwarding)
//   wb_addrE, RegWriteE, MemtoRegE EX destination, writes, is-load
//   wb_addrM, RegWriteM, MemtoRegM MEM destination, writes, is-load
//   wb_addrW, RegWriteW            WB destination, writes
//   branch_takenE                  branch resolved taken in EX
//   STALL_F, STALL_D               hold PC / hold IF/ID
//   EX_NOP, JR_EX_NOP              bubble into ID/EX (generic / JR wait)
//   FLUSH_D                        squash IF/ID
//   ForwardAE, ForwardBE           00 regfile, 10 MEM ALU result, 01 WB value
//   hazard_state                   winning action of the previous cycle
//   jr_wait_cnt, jr_timeout        JR wait counter and sticky watchdog flag
//   stall_count, flush_count       saturating event counters
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int JR_MAX_WAIT = 2,
  parameter int CNT_W       = 16
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             ENABLED,
  input  logic [4:0]       rs_addrD,
  input  logic [4:0]       rt_addrD,
  input  logic             use_rsD,
  input  logic             use_rtD,
  input  logic             jrD,
  input  logic [4:0]       rs_addrE,
  input  logic [4:0]       rt_addrE,
  input  logic [4:0]       wb_addrE,
  input  logic             RegWriteE,
  input  logic             MemtoRegE,
  input  logic [4:0]       wb_addrM,
  input  logic             RegWriteM,
  input  logic             MemtoRegM,
  input  logic [4:0]       wb_addrW,
  input  logic             RegWriteW,
  input  logic             branch_takenE,
  output logic             STALL_F,
  output logic             STALL_D,
  output logic             EX_NOP,
  output logic             JR_EX_NOP,
  output logic             FLUSH_D,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [1:0]       hazard_state,
  output logic [1:0]       jr_wait_cnt,
  output logic             jr_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    JR_WAIT  = 2'd2,
    BR_FLUSH = 2'd3
  } hazardState_e;

  hazardState_e stateReg;
  hazardState_e nextState;

  logic luHaz;
  logic jwHaz;
  logic jgHaz;
  logic brHaz;

  // Raw hazard conditions. Register 0 is hard-wired zero, so it never
  // creates a dependency.
  always_comb begin
    luHaz = ENABLED && RegWriteE && MemtoRegE && (wb_addrE != 5'd0) &&
            ((use_rsD && (rs_addrD == wb_addrE)) ||
             (use_rtD && (rt_addrD == wb_addrE)));
    jwHaz = ENABLED && jrD && (rs_addrD != 5'd0) &&
            ((RegWriteE && (wb_addrE == rs_addrD)) ||
             (RegWriteM && (wb_addrM == rs_addrD)));
    jgHaz = ENABLED && jrD && !jwHaz;
    brHaz = branch_takenE;
  end

  // State register: remembers which action won in the cycle just ended.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      stateReg <= RUN;
    end else begin
      stateReg <= nextState;
    end
  end

  // Next-state: the taken branch outranks everything because the younger
  // instructions are wrong-path; a JR wait outranks a load-use stall.
  always_comb begin
    nextState = RUN;
    if (brHaz) begin
      nextState = BR_FLUSH;
    end else if (jwHaz) begin
      nextState = JR_WAIT;
    end else if (luHaz) begin
      nextState = LU_STALL;
    end
  end

  // Control outputs. They follow the same priority as the next-state logic;
  // JR go is not a stored state but still squashes the fall-through fetch.
  // While reset is held the pipeline is forced to bubble and flush.
  always_comb begin
    STALL_F   = 1'b0;
    STALL_D   = 1'b0;
    EX_NOP    = 1'b0;
    JR_EX_NOP = 1'b0;
    FLUSH_D   = 1'b0;
    if (!RESET_N) begin
      EX_NOP  = 1'b1;
      FLUSH_D = 1'b1;
    end else if (nextState == BR_FLUSH) begin
      FLUSH_D = 1'b1;
      EX_NOP  = 1'b1;
    end else if (nextState == JR_WAIT) begin
      STALL_F   = 1'b1;
      STALL_D   = 1'b1;
      JR_EX_NOP = 1'b1;
    end else if (nextState == LU_STALL) begin
      STALL_F = 1'b1;
      STALL_D = 1'b1;
      EX_NOP  = 1'b1;
    end else if (jgHaz) begin
      FLUSH_D = 1'b1;
    end
  end

  // Operand bypass selects. MEM wins over WB because it holds the younger
  // value; a load in MEM has no data yet, so it cannot feed the bypass.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RESET_N) begin
      if (RegWriteM && !MemtoRegM && (wb_addrM != 5'd0) && (wb_addrM == rs_addrE)) begin
        ForwardAE = 2'b10;
      end else if (RegWriteW && (wb_addrW != 5'd0) && (wb_addrW == rs_addrE)) begin
        ForwardAE = 2'b01;
      end
      if (RegWriteM && !MemtoRegM && (wb_addrM != 5'd0) && (wb_addrM == rt_addrE)) begin
        ForwardBE = 2'b10;
      end else if (RegWriteW && (wb_addrW != 5'd0) && (wb_addrW == rt_addrE)) begin
        ForwardBE = 2'b01;
      end
    end
  end

  assign hazard_state = stateReg;

  // JR watchdog: count consecutive cycles in which a JR wait actually wins,
  // saturating at 3. The timeout flag is sticky until reset.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      jr_wait_cnt <= 2'd0;
      jr_timeout  <= 1'b0;
    end else if (nextState == JR_WAIT) begin
      if (jr_wait_cnt != 2'd3) begin
        jr_wait_cnt <= jr_wait_cnt + 2'd1;
      end
      if (int'(jr_wait_cnt) == JR_MAX_WAIT) begin
        jr_timeout <= 1'b1;
      end
    end else begin
      jr_wait_cnt <= 2'd0;
    end
  end

  // Statistics counters follow the visible controls, so a branch that
  // overrides a stall only bumps the flush count. Both stick at all-ones.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (STALL_D && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
      if (FLUSH_D && (flush_count != '1)) begin
        flush_count <= flush_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed bench for hazard_ctrl with CNT_W=4 so counter saturation is quick
// to reach. Inputs change on the falling clock edge and outputs are sampled
// 1 ns later, well clear of the rising edge that updates the registers.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int CNT_W = 4;

  logic             CLOCK;
  logic             RESET_N;
  logic             ENABLED;
  logic [4:0]       rs_addrD, rt_addrD;
  logic             use_rsD, use_rtD, jrD;
  logic [4:0]       rs_addrE, rt_addrE;
  logic [4:0]       wb_addrE, wb_addrM, wb_addrW;
  logic             RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, RegWriteW;
  logic             branch_takenE;
  logic             STALL_F, STALL_D, EX_NOP, JR_EX_NOP, FLUSH_D;
  logic [1:0]       ForwardAE, ForwardBE, hazard_state, jr_wait_cnt;
  logic             jr_timeout;
  logic [CNT_W-1:0] stall_count, flush_count;

  int assertCount = 0;
  int failCount   = 0;

  hazard_ctrl #(.JR_MAX_WAIT(2), .CNT_W(CNT_W)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .ENABLED(ENABLED),
    .rs_addrD(rs_addrD), .rt_addrD(rt_addrD),
    .use_rsD(use_rsD), .use_rtD(use_rtD), .jrD(jrD),
    .rs_addrE(rs_addrE), .rt_addrE(rt_addrE),
    .wb_addrE(wb_addrE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
    .wb_addrM(wb_addrM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .wb_addrW(wb_addrW), .RegWriteW(RegWriteW),
    .branch_takenE(branch_takenE),
    .STALL_F(STALL_F), .STALL_D(STALL_D), .EX_NOP(EX_NOP),
    .JR_EX_NOP(JR_EX_NOP), .FLUSH_D(FLUSH_D),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .hazard_state(hazard_state), .jr_wait_cnt(jr_wait_cnt),
    .jr_timeout(jr_timeout),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive the ID-stage instruction and the EX producer; everything else idles.
  task automatic applyStimulus(input logic en, input logic [4:0] rsD,
                               input logic [4:0] rtD, input logic useRs,
                               input logic useRt, input logic jr,
                               input logic [4:0] wbE, input logic regWrE,
                               input logic memToRegE, input logic br);
    ENABLED       = en;
    rs_addrD      = rsD;
    rt_addrD      = rtD;
    use_rsD       = useRs;
    use_rtD       = useRt;
    jrD           = jr;
    wb_addrE      = wbE;
    RegWriteE     = regWrE;
    MemtoRegE     = memToRegE;
    branch_takenE = br;
    rs_addrE      = 5'd0;
    rt_addrE      = 5'd0;
    wb_addrM      = 5'd0;
    RegWriteM     = 1'b0;
    MemtoRegM     = 1'b0;
    wb_addrW      = 5'd0;
    RegWriteW     = 1'b0;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Move to the next falling edge; the rising edge in between is the update.
  task automatic nextCycle();
    @(negedge CLOCK);
  endtask

  initial begin
    RESET_N = 1'b0;
    idle();
    #2;
    checkOutput("rst_EX_NOP", EX_NOP, 1);
    checkOutput("rst_FLUSH_D", FLUSH_D, 1);
    checkOutput("rst_STALL_D", STALL_D, 0);
    checkOutput("rst_state", hazard_state, 0);
    checkOutput("rst_stall_count", stall_count, 0);
    nextCycle();
    RESET_N = 1'b1;
    #1;
    checkOutput("idle_FLUSH_D", FLUSH_D, 0);

    // Load-use: lw $8 in EX, add reading $8 in ID.
    $display("[TB] load-use stall");
    nextCycle();
    applyStimulus(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
    #1;
    checkOutput("lu_STALL_F", STALL_F, 1);
    checkOutput("lu_STALL_D", STALL_D, 1);
    checkOutput("lu_EX_NOP", EX_NOP, 1);
    checkOutput("lu_FLUSH_D", FLUSH_D, 0);
    nextCycle();
    // Load now in MEM, bubble in EX, add still in ID.
    applyStimulus(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    wb_addrM = 5'd8; RegWriteM = 1'b1; MemtoRegM = 1'b1;
    #1;
    checkOutput("lu_next_STALL_D", STALL_D, 0);
    checkOutput("lu_next_EX_NOP", EX_NOP, 0);
    checkOutput("lu_state", hazard_state, 1);
    checkOutput("lu_stall_count", stall_count, 1);
    nextCycle();
    // Load in WB, add in EX.
    idle();
    rs_addrE = 5'd8; wb_addrW = 5'd8; RegWriteW = 1'b1;
    #1;
    checkOutput("lu_fwd_A", ForwardAE, 2'b01);
    checkOutput("lu_state_run", hazard_state, 0);
    checkOutput("lu_stall_count2", stall_count, 1);

    // Forwarding priority (purely combinational).
    $display("[TB] forwarding priority");
    nextCycle();
    idle();
    rs_addrE = 5'd5; rt_addrE = 5'd5;
    wb_addrM = 5'd5; RegWriteM = 1'b1; MemtoRegM = 1'b0;
    wb_addrW = 5'd5; RegWriteW = 1'b1;
    #1;
    checkOutput("fwd_A_mem", ForwardAE, 2'b10);
    checkOutput("fwd_B_mem", ForwardBE, 2'b10);
    MemtoRegM = 1'b1;
    #1;
    checkOutput("fwd_A_wb", ForwardAE, 2'b01);
    rs_addrE = 5'd0;
    #1;
    checkOutput("fwd_A_r0", ForwardAE, 2'b00);
    checkOutput("fwd_B_wb", ForwardBE, 2'b01);

    // JR $9 behind a load to $9.
    $display("[TB] jr behind load");
    nextCycle();
    applyStimulus(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0);
    #1;
    checkOutput("jr1_JR_EX_NOP", JR_EX_NOP, 1);
    checkOutput("jr1_STALL_D", STALL_D, 1);
    checkOutput("jr1_EX_NOP", EX_NOP, 0);
    nextCycle();
    applyStimulus(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    wb_addrM = 5'd9; RegWriteM = 1'b1; MemtoRegM = 1'b1;
    #1;
    checkOutput("jr2_JR_EX_NOP", JR_EX_NOP, 1);
    checkOutput("jr2_wait_cnt", jr_wait_cnt, 1);
    checkOutput("jr2_state", hazard_state, 2);
    nextCycle();
    applyStimulus(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    wb_addrW = 5'd9; RegWriteW = 1'b1;
    #1;
    checkOutput("jg_FLUSH_D", FLUSH_D, 1);
    checkOutput("jg_JR_EX_NOP", JR_EX_NOP, 0);
    checkOutput("jg_STALL_D", STALL_D, 0);
    checkOutput("jg_wait_cnt", jr_wait_cnt, 2);
    nextCycle();
    idle();
    #1;
    checkOutput("jg_after_FLUSH_D", FLUSH_D, 0);
    checkOutput("jg_after_wait_cnt", jr_wait_cnt, 0);
    checkOutput("jg_timeout", jr_timeout, 0);
    checkOutput("jg_flush_count", flush_count, 1);
    checkOutput("jg_stall_count", stall_count, 3);

    // Watchdog: JR waits behind an ALU producer held in EX for 3 cycles.
    $display("[TB] jr watchdog");
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      applyStimulus(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
      #1;
      checkOutput("wd_timeout_pre", jr_timeout, 0);
      checkOutput("wd_wait_cnt", jr_wait_cnt, i);
    end
    nextCycle();
    idle();
    #1;
    checkOutput("wd_timeout_set", jr_timeout, 1);
    checkOutput("wd_wait_cnt_sat", jr_wait_cnt, 3);
    nextCycle();
    #1;
    checkOutput("wd_timeout_sticky", jr_timeout, 1);
    checkOutput("wd_wait_cnt_clr", jr_wait_cnt, 0);
    checkOutput("wd_stall_count", stall_count, 6);

    // Taken branch together with a load-use hazard.
    $display("[TB] branch priority");
    nextCycle();
    applyStimulus(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b1);
    #1;
    checkOutput("br_FLUSH_D", FLUSH_D, 1);
    checkOutput("br_EX_NOP", EX_NOP, 1);
    checkOutput("br_STALL_D", STALL_D, 0);
    checkOutput("br_STALL_F", STALL_F, 0);
    nextCycle();
    idle();
    #1;
    checkOutput("br_state", hazard_state, 3);
    checkOutput("br_flush_count", flush_count, 2);
    checkOutput("br_stall_count", stall_count, 6);

    // Reset asserted in the middle of a JR wait, between clock edges.
    $display("[TB] async reset mid-wait");
    nextCycle();
    applyStimulus(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("rw_JR_EX_NOP_pre", JR_EX_NOP, 1);
    RESET_N = 1'b0;
    #1;
    checkOutput("rw_JR_EX_NOP", JR_EX_NOP, 0);
    checkOutput("rw_EX_NOP", EX_NOP, 1);
    checkOutput("rw_FLUSH_D", FLUSH_D, 1);
    checkOutput("rw_STALL_D", STALL_D, 0);
    checkOutput("rw_stall_count", stall_count, 0);
    checkOutput("rw_flush_count", flush_count, 0);
    checkOutput("rw_timeout", jr_timeout, 0);
    checkOutput("rw_state", hazard_state, 0);
    nextCycle();
    idle();
    RESET_N = 1'b1;

    // Saturation: 20 back-to-back load-use stalls on a 4-bit counter.
    $display("[TB] stall counter saturation");
    for (int i = 0; i < 20; i++) begin
      nextCycle();
      applyStimulus(1'b1, 5'd0, 5'd3, 1'b0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
    end
    nextCycle();
    idle();
    #1;
    checkOutput("sat_stall_count", stall_count, 15);
    checkOutput("sat_state", hazard_state, 1);
    checkOutput("sat_flush_count", flush_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
